matrix_loader_3x3: RTL and testbench

- Write side of the packed-matrix interface: accepts signed 8-bit elements one per handshake and assembles them into the 72-bit row-major packed matrix that the determinant and other operation units consume.
- Sits between the host/bus input stream and the operation units.
- Holds the completed matrix stable until the consumer accepts it.
- Checks frame length with in_last and resynchronises after framing errors.

---
 rtl/matrix_loader_3x3_pkg.sv | 22 ++
 rtl/matrix_loader_3x3_if.sv | 28 ++
 rtl/matrix_loader_3x3.sv | 110 +++++++++++
 tb/tb_matrix_loader_3x3.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_loader_3x3_pkg.sv
// Shared matrix geometry, loader state encoding and slot-offset helper.
// Used by the loader and by anything consuming the packed row-major matrix.
package matrix_pkg;

   localparam int MAT_N  = 3;
   localparam int ELEM_W = 8;
   localparam int MAT_W  = MAT_N * MAT_N * ELEM_W;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } ld_state_t;

   // Element 0 lands in the most significant slot so the matrix reads a..i left to right.
   function automatic int unsigned slot_lsb(input int unsigned k,
                                            input int unsigned n = MAT_N,
                                            input int unsigned w = ELEM_W);
      return (n * n - 1 - k) * w;
   endfunction

endpackage

// File: rtl/matrix_loader_3x3_if.sv
// Element stream in (valid/ready/last) and packed matrix out (valid/ready).
// slave is the loader's view, master is the host/consumer side.
interface matrix_loader_3x3_if
   import matrix_pkg::*;
#(
   parameter int N      = MAT_N,
   parameter int DATA_W = ELEM_W
) ();

   logic signed [DATA_W-1:0]     in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic                         in_last;
   logic [N*N*DATA_W-1:0]        out_matrix;
   logic                         out_valid;
   logic                         out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_matrix, out_valid
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_matrix, out_valid
   );

endinterface

// File: rtl/matrix_loader_3x3.sv
// Packs N*N streamed elements into a row-major matrix; out_valid 1 cycle after last element,
// in_ready low while the matrix is held. MATRIX_LOADER_ERRCNT_EN adds a saturating err_count.
module matrix_loader_3x3
   import matrix_pkg::*;
#(
   parameter int N      = MAT_N,
   parameter int DATA_W = ELEM_W
) (
   input  logic                 clk,
   input  logic                 reset,
   matrix_loader_3x3_if.slave   bus,
   output logic                 frame_err
`ifdef MATRIX_LOADER_ERRCNT_EN
   ,
   output logic [7:0]           err_count
`endif
);

   localparam int ELEMS = N * N;
   localparam int IDX_W = $clog2(ELEMS);
   localparam int MW    = ELEMS * DATA_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);

   ld_state_t        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [MW-1:0]    mat_q, mat_d;
   logic             frame_err_q, frame_err_d;
   logic             accept;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mat_d       = mat_q;
      frame_err_d = 1'b0;
      accept      = bus.in_valid && (state_q != FULL);

      unique case (state_q)
         LOAD: begin
            if (accept) begin
               if (idx_q == IDX_LAST && bus.in_last) begin
                  mat_d[slot_lsb(32'(idx_q), N, DATA_W) +: DATA_W] = bus.in_data;
                  idx_d   = '0;
                  state_d = FULL;
               end else if (bus.in_last || idx_q == IDX_LAST) begin
                  // Short frame resyncs immediately; long frame swallows the rest up to in_last.
                  mat_d       = '0;
                  idx_d       = '0;
                  frame_err_d = 1'b1;
                  state_d     = bus.in_last ? LOAD : DRAIN;
               end else begin
                  mat_d[slot_lsb(32'(idx_q), N, DATA_W) +: DATA_W] = bus.in_data;
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               state_d = LOAD;
            end
         end
         DRAIN: begin
            if (accept && bus.in_last) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         mat_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mat_q       <= mat_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.in_ready   = (state_q != FULL);
   assign bus.out_valid  = (state_q == FULL);
   assign bus.out_matrix = mat_q;
   assign frame_err      = frame_err_q;

`ifdef MATRIX_LOADER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_q && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_loader_3x3.sv
// Bench for matrix_loader_3x3: frame-level model compared every cycle, scoreboard of packed frames,
// and literal expectations for the directed cases.
module tb_matrix_loader_3x3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_err;
`ifdef MATRIX_LOADER_ERRCNT_EN
   logic [7:0] err_count;
`endif

   matrix_loader_3x3_if bus_if ();

   matrix_loader_3x3 dut (
      .clk       (clk),
      .reset     (rst),
      .bus       (bus_if),
      .frame_err (frame_err)
`ifdef MATRIX_LOADER_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Frame-level model: elements collected so far, whether a matrix is held, whether draining.
   logic [7:0]  m_mat [9];
   int          m_cnt = 0;
   bit          m_full = 0, m_drain = 0, m_err = 0, live = 0;
   int          m_ec = 0;
   logic [71:0] sb_q [$];
   bit          sb_on = 0;
   bit          ordy_done = 0;

   function automatic logic [71:0] m_pack();
      logic [71:0] p = '0;
      for (int k = 0; k < 9; k++) p = {p[63:0], m_mat[k]};
      return p;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit e;
      if (rst) begin
         m_cnt = 0; m_full = 0; m_drain = 0; m_err = 0; m_ec = 0; live = 1;
         for (int k = 0; k < 9; k++) m_mat[k] = 8'h00;
      end else begin
         e = 0;
         if (m_full) begin
            if (bus_if.out_ready) m_full = 0;
         end else if (bus_if.in_valid) begin
            if (m_drain) begin
               if (bus_if.in_last) m_drain = 0;
            end else begin
               m_mat[m_cnt] = bus_if.in_data;
               m_cnt++;
               if (m_cnt == 9 && bus_if.in_last) begin
                  m_full = 1;
                  m_cnt  = 0;
               end else if (bus_if.in_last || m_cnt == 9) begin
                  e       = 1;
                  m_drain = !bus_if.in_last;
                  m_cnt   = 0;
                  for (int k = 0; k < 9; k++) m_mat[k] = 8'h00;
               end
            end
         end
         if (m_err && m_ec != 255) m_ec++;
         m_err = e;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("cyc_out_valid", bus_if.out_valid, m_full);
         chk("cyc_in_ready", bus_if.in_ready, !m_full);
         chk("cyc_frame_err", frame_err, m_err);
         chk("cyc_out_matrix", bus_if.out_matrix, m_pack());
`ifdef MATRIX_LOADER_ERRCNT_EN
         chk("cyc_err_count", err_count, m_ec[7:0]);
`endif
         if (sb_on && bus_if.out_valid && bus_if.out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual=%h required=no_frame", bus_if.out_matrix);
            end else begin
               chk("sb_frame", bus_if.out_matrix, sb_q.pop_front());
            end
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      bus_if.in_data  = 8'($urandom);
   endtask

   task automatic send(input logic [7:0] d, input bit l, input int gap);
      int t;
      repeat (gap) idle();
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      bus_if.in_last  = l;
      t = 0;
      while (!bus_if.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready=%0b required=1", bus_if.in_ready);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.in_valid  = 1'b0;
      bus_if.in_last   = 1'b0;
      bus_if.in_data   = 8'h00;
      bus_if.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", bus_if.out_valid, 0);
      chk("rst_out_matrix", bus_if.out_matrix, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus_if.in_ready, 1);

      // 1..9 with immediate consumer
      for (int k = 1; k <= 9; k++) send(8'(k), k == 9, 0);
      idle();
      chk("t1_valid", bus_if.out_valid, 1);
      chk("t1_matrix", bus_if.out_matrix, 72'h010203040506070809);
      idle();
      chk("t1_valid_fall", bus_if.out_valid, 0);

      // identity held under backpressure
      bus_if.out_ready = 1'b0;
      for (int k = 0; k < 9; k++) send((k % 4 == 0) ? 8'h01 : 8'h00, k == 8, 0);
      idle();
      chk("t2_valid", bus_if.out_valid, 1);
      repeat (5) begin
         @(negedge clk);
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = 8'hAA;
         bus_if.in_last  = 1'b1;
         chk("t2_in_ready_held", bus_if.in_ready, 0);
         chk("t2_matrix_held", bus_if.out_matrix, 72'h010000000100000001);
      end
      idle();
      chk("t2_valid_held", bus_if.out_valid, 1);
      bus_if.out_ready = 1'b1;
      idle();
      chk("t2_valid_fall", bus_if.out_valid, 0);
      chk("t2_matrix_kept", bus_if.out_matrix, 72'h010000000100000001);

      // short frame then all-ones frame
      for (int k = 0; k < 4; k++) send(8'(5 + k), k == 3, 0);
      idle();
      chk("t3_err", frame_err, 1);
      chk("t3_no_valid", bus_if.out_valid, 0);
      chk("t3_cleared", bus_if.out_matrix, 0);
      idle();
      chk("t3_err_one_cycle", frame_err, 0);
      for (int k = 0; k < 9; k++) send(8'hFF, k == 8, 0);
      idle();
      chk("t3_ones", bus_if.out_matrix, 72'hFFFFFFFFFFFFFFFFFF);
      idle();

      // long frame: error on element 9, 10..11 discarded
      for (int k = 1; k <= 11; k++) begin
         send(8'(8'h10 + k), k == 11, 0);
         if (k == 10) chk("t4_err_at_9", frame_err, 1);
      end
      idle();
      chk("t4_no_extra_err", frame_err, 0);
      chk("t4_no_valid", bus_if.out_valid, 0);
      for (int k = 0; k < 9; k++) send(8'(8'h80 + k), k == 8, 0);
      idle();
      chk("t4_next_frame", bus_if.out_matrix, 72'h808182838485868788);
      idle();

      // reset mid-frame
      for (int k = 0; k < 5; k++) send(8'(8'h31 + k), 1'b0, 0);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_valid", bus_if.out_valid, 0);
      chk("t5_matrix", bus_if.out_matrix, 0);
      chk("t5_in_ready", bus_if.in_ready, 1);
      for (int k = 0; k < 9; k++) send(8'(8'h21 + k), k == 8, 0);
      idle();
      chk("t5_frame", bus_if.out_matrix, 72'h212223242526272829);
      idle();

      // 100 frames, random gaps and consumer stalls, every 10th one short
      sb_on = 1;
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               bit          short_f;
               int          n;
               logic [7:0]  d [9];
               logic [71:0] e;
               short_f = (f % 10 == 7);
               n = short_f ? 3 : 9;
               e = '0;
               for (int k = 0; k < n; k++) begin
                  d[k] = 8'($urandom);
                  e = {e[63:0], d[k]};
               end
               if (!short_f) sb_q.push_back(e);
               for (int k = 0; k < n; k++) send(d[k], k == n - 1, int'($urandom_range(0, 1)));
            end
            idle();
            for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
            ordy_done = 1;
         end
         begin
            while (!ordy_done) begin
               @(posedge clk);
               #1;
               bus_if.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      chk("t6_sb_drained", 72'(sb_q.size()), 0);
      sb_on = 0;
      bus_if.out_ready = 1'b1;
      idle();
      idle();

`ifdef MATRIX_LOADER_ERRCNT_EN
      for (int i = 0; i < 300; i++) send(8'(i), 1'b1, 0);
      idle();
      idle();
      chk("t7_err_count_sat", err_count, 255);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
